// File: rtl/hazard_sequencer_if.sv
// Signal bundle between the pipeline datapath and the hazard sequencer.
// The datapath side (master) supplies hazard inputs; the sequencer (slave) returns the control enables.
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             branch_taken;
    logic             dmem_wait;
    logic             cnt_clear;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             control_valid;
    logic             pipe_hold;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, dmem_wait, cnt_clear,
        input  pc_write, if_id_write, if_id_flush, control_valid,
               pipe_hold, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, dmem_wait, cnt_clear,
        output pc_write, if_id_write, if_id_flush, control_valid,
               pipe_hold, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory freeze, and saturating stall/flush counters.
module hazard_sequencer #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_sequencer_if.slave  hz
);
    localparam int REM_MAX = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int REM_W   = (REM_MAX > 1) ? $clog2(REM_MAX + 1) : 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [REM_W-1:0] r_rem;
    logic [REM_W-1:0] w_next_rem;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lu;
    logic w_stall_inc;
    logic w_flush_inc;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_control_valid;
    logic w_pipe_hold;

    assign w_lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                  ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_rem   <= '0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_rem      = r_rem;
        w_stall_inc     = 1'b0;
        w_flush_inc     = 1'b0;
        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_if_id_flush   = 1'b0;
        w_control_valid = 1'b1;
        w_pipe_hold     = 1'b0;

        if (!rst_n) begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_control_valid = 1'b0;
        end else if (hz.dmem_wait) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_pipe_hold   = 1'b1;
        end else if (hz.branch_taken) begin
            // A branch wins in every state: it aborts a stall or restarts a flush sequence.
            w_if_id_flush = 1'b1;
            w_flush_inc   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_next_state = S_FLUSH;
                w_next_rem   = REM_W'(FLUSH_CYCLES - 1);
            end else begin
                w_next_state = S_RUN;
                w_next_rem   = '0;
            end
        end else begin
            case (r_state)
                S_STALL: begin
                    w_pc_write      = 1'b0;
                    w_if_id_write   = 1'b0;
                    w_control_valid = 1'b0;
                    w_stall_inc     = 1'b1;
                    w_next_rem      = r_rem - REM_W'(1);
                    if (r_rem == REM_W'(1)) begin
                        w_next_state = S_RUN;
                    end
                end
                S_FLUSH: begin
                    w_if_id_flush = 1'b1;
                    w_flush_inc   = 1'b1;
                    w_next_rem    = r_rem - REM_W'(1);
                    if (r_rem == REM_W'(1)) begin
                        w_next_state = S_RUN;
                    end
                end
                default: begin
                    if (w_lu) begin
                        w_pc_write      = 1'b0;
                        w_if_id_write   = 1'b0;
                        w_control_valid = 1'b0;
                        w_stall_inc     = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_next_state = S_STALL;
                            w_next_rem   = REM_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (hz.cnt_clear) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.pc_write      = w_pc_write;
    assign hz.if_id_write   = w_if_id_write;
    assign hz.if_id_flush   = w_if_id_flush;
    assign hz.control_valid = w_control_valid;
    assign hz.pipe_hold     = w_pipe_hold;
    assign hz.stall_cnt     = r_stall_cnt;
    assign hz.flush_cnt     = r_flush_cnt;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: three instances (default, long stall/flush, 4-bit counters)
// share one set of input stimulus.
module tb_hazard_sequencer;
    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       branch_taken;
    logic       dmem_wait;
    logic       cnt_clear;

    int errors;
    int checks;

    hazard_sequencer_if #(.CNT_W(16)) if_a ();
    hazard_sequencer_if #(.CNT_W(16)) if_b ();
    hazard_sequencer_if #(.CNT_W(4))  if_c ();

    assign if_a.id_rs = id_rs;               assign if_b.id_rs = id_rs;               assign if_c.id_rs = id_rs;
    assign if_a.id_rt = id_rt;               assign if_b.id_rt = id_rt;               assign if_c.id_rt = id_rt;
    assign if_a.id_uses_rt = id_uses_rt;     assign if_b.id_uses_rt = id_uses_rt;     assign if_c.id_uses_rt = id_uses_rt;
    assign if_a.ex_mem_read = ex_mem_read;   assign if_b.ex_mem_read = ex_mem_read;   assign if_c.ex_mem_read = ex_mem_read;
    assign if_a.ex_rt = ex_rt;               assign if_b.ex_rt = ex_rt;               assign if_c.ex_rt = ex_rt;
    assign if_a.branch_taken = branch_taken; assign if_b.branch_taken = branch_taken; assign if_c.branch_taken = branch_taken;
    assign if_a.dmem_wait = dmem_wait;       assign if_b.dmem_wait = dmem_wait;       assign if_c.dmem_wait = dmem_wait;
    assign if_a.cnt_clear = cnt_clear;       assign if_b.cnt_clear = cnt_clear;       assign if_c.cnt_clear = cnt_clear;

    hazard_sequencer #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_a (.clk(clk), .rst_n(rst_n), .hz(if_a));
    hazard_sequencer #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(16)) u_b (.clk(clk), .rst_n(rst_n), .hz(if_b));
    hazard_sequencer #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(4))  u_c (.clk(clk), .rst_n(rst_n), .hz(if_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_rt = 5'd0; branch_taken = 1'b0; dmem_wait = 1'b0; cnt_clear = 1'b0;
    endtask

    // Load in EX writes r5, instruction in ID reads r5 through rs.
    task automatic drive_lu();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++; if (if_a.pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write: got %b want 0", if_a.pc_write); end
        checks++; if (if_a.control_valid !== 1'b0) begin errors++; $display("FAIL rst_control_valid: got %b want 0", if_a.control_valid); end
        checks++; if (if_a.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d want 0", if_a.stall_cnt); end
        tick();
        rst_n = 1'b1;
        drive_lu();
        tick();
        idle_inputs();
        #1;
        checks++; if (if_b.control_valid !== 1'b0) begin errors++; $display("FAIL rst_in_stall: got %b want 0", if_b.control_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if ({if_b.pc_write, if_b.if_id_write, if_b.if_id_flush, if_b.control_valid, if_b.pipe_hold} !== 5'b00000) begin
            errors++; $display("FAIL rst_mid_stall_outs: got %b want 00000",
                {if_b.pc_write, if_b.if_id_write, if_b.if_id_flush, if_b.control_valid, if_b.pipe_hold});
        end
        checks++; if (if_b.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_stall_cnt: got %0d want 0", if_b.stall_cnt); end
        rst_n = 1'b1;
        #1;
        checks++; if ({if_b.pc_write, if_b.control_valid} !== 2'b11) begin
            errors++; $display("FAIL rst_release_run: got %b want 11", {if_b.pc_write, if_b.control_valid});
        end
        tick();
        checks++; if ({if_b.pc_write, if_b.if_id_write, if_b.control_valid} !== 3'b111) begin
            errors++; $display("FAIL rst_after_release: got %b want 111", {if_b.pc_write, if_b.if_id_write, if_b.control_valid});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_lu();
        #1;
        checks++; if ({if_a.pc_write, if_a.if_id_write, if_a.control_valid} !== 3'b000) begin
            errors++; $display("FAIL lu_outs: got %b want 000", {if_a.pc_write, if_a.if_id_write, if_a.control_valid});
        end
        tick();
        checks++; if (if_a.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 1", if_a.stall_cnt); end
        idle_inputs();
        #1;
        checks++; if ({if_a.pc_write, if_a.control_valid} !== 2'b11) begin
            errors++; $display("FAIL lu_one_cycle: got %b want 11", {if_a.pc_write, if_a.control_valid});
        end
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        checks++; if ({if_a.pc_write, if_a.control_valid} !== 2'b11) begin
            errors++; $display("FAIL lu_r0_nostall: got %b want 11", {if_a.pc_write, if_a.control_valid});
        end
        tick();
        checks++; if (if_a.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_r0_cnt: got %0d want 1", if_a.stall_cnt); end
    endtask

    task automatic test_multi_stall();
        int bubbles;
        do_reset();
        drive_lu();
        bubbles = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (if_b.control_valid === 1'b0) bubbles++;
            tick();
            idle_inputs();
        end
        checks++; if (bubbles !== 3) begin errors++; $display("FAIL stall3_bubbles: got %0d want 3", bubbles); end
        checks++; if (if_b.stall_cnt !== 16'd3) begin errors++; $display("FAIL stall3_cnt: got %0d want 3", if_b.stall_cnt); end
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b0;
        #1;
        checks++; if (if_b.control_valid !== 1'b1) begin errors++; $display("FAIL rt_unused_nostall: got %b want 1", if_b.control_valid); end
        id_uses_rt = 1'b1;
        #1;
        checks++; if (if_b.control_valid !== 1'b0) begin errors++; $display("FAIL rt_used_stall: got %b want 0", if_b.control_valid); end
        idle_inputs();
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        drive_lu();
        branch_taken = 1'b1;
        #1;
        checks++; if ({if_b.if_id_flush, if_b.control_valid, if_b.pc_write} !== 3'b111) begin
            errors++; $display("FAIL br_lu_b: got %b want 111", {if_b.if_id_flush, if_b.control_valid, if_b.pc_write});
        end
        checks++; if ({if_a.if_id_flush, if_a.control_valid} !== 2'b11) begin
            errors++; $display("FAIL br_lu_a: got %b want 11", {if_a.if_id_flush, if_a.control_valid});
        end
        tick();
        branch_taken = 1'b0;
        #1;
        checks++; if ({if_b.if_id_flush, if_b.control_valid} !== 2'b11) begin
            errors++; $display("FAIL br_flush2_b: got %b want 11", {if_b.if_id_flush, if_b.control_valid});
        end
        checks++; if ({if_a.if_id_flush, if_a.control_valid} !== 2'b00) begin
            errors++; $display("FAIL br_after_a: got %b want 00", {if_a.if_id_flush, if_a.control_valid});
        end
        tick();
        idle_inputs();
        #1;
        checks++; if ({if_b.if_id_flush, if_b.control_valid} !== 2'b01) begin
            errors++; $display("FAIL br_done_b: got %b want 01", {if_b.if_id_flush, if_b.control_valid});
        end
        tick();
        checks++; if (if_b.flush_cnt !== 16'd2) begin errors++; $display("FAIL br_flush_cnt_b: got %0d want 2", if_b.flush_cnt); end
        checks++; if (if_b.stall_cnt !== 16'd0) begin errors++; $display("FAIL br_stall_cnt_b: got %0d want 0", if_b.stall_cnt); end
        checks++; if ({if_a.flush_cnt, if_a.stall_cnt} !== {16'd1, 16'd1}) begin
            errors++; $display("FAIL br_cnts_a: got %0d/%0d want 1/1", if_a.flush_cnt, if_a.stall_cnt);
        end
    endtask

    task automatic test_dmem_wait();
        int bubbles;
        int hold_bad;
        do_reset();
        drive_lu();
        tick();
        idle_inputs();
        dmem_wait = 1'b1;
        hold_bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if ({if_b.pipe_hold, if_b.pc_write, if_b.if_id_write, if_b.if_id_flush, if_b.control_valid} !== 5'b10001) hold_bad++;
            tick();
        end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL dwait_outs: got %0d bad cycles want 0", hold_bad); end
        checks++; if (if_b.stall_cnt !== 16'd1) begin errors++; $display("FAIL dwait_cnt_held: got %0d want 1", if_b.stall_cnt); end
        dmem_wait = 1'b0;
        bubbles = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (if_b.control_valid === 1'b0) bubbles++;
            tick();
        end
        checks++; if (bubbles !== 2) begin errors++; $display("FAIL dwait_resume_bubbles: got %0d want 2", bubbles); end
        checks++; if (if_b.stall_cnt !== 16'd3) begin errors++; $display("FAIL dwait_total_cnt: got %0d want 3", if_b.stall_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive_lu();
        for (int i = 0; i < 15; i++) tick();
        checks++; if (if_c.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_at_15: got %0d want 15", if_c.stall_cnt); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (if_c.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", if_c.stall_cnt); end
        checks++; if (if_a.stall_cnt !== 16'd20) begin errors++; $display("FAIL nosat_wide: got %0d want 20", if_a.stall_cnt); end
        idle_inputs();
        dmem_wait = 1'b1;
        cnt_clear = 1'b1;
        tick();
        checks++; if (if_c.stall_cnt !== 4'd0) begin errors++; $display("FAIL clear_in_wait: got %0d want 0", if_c.stall_cnt); end
        checks++; if (if_a.stall_cnt !== 16'd0) begin errors++; $display("FAIL clear_wide: got %0d want 0", if_a.stall_cnt); end
        idle_inputs();
        drive_lu();
        cnt_clear = 1'b1;
        tick();
        checks++; if (if_c.stall_cnt !== 4'd0) begin errors++; $display("FAIL clear_over_inc: got %0d want 0", if_c.stall_cnt); end
        idle_inputs();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_multi_stall();
        test_branch();
        test_dmem_wait();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
